pin_verifier: RTL

//  Stage directly downstream of the card swiper. On a newly scanned card it fetches the stored
//  PIN and lock flag for acc_addr, then collects keypad digits and compares them with the stored PIN.

---
 rtl/pin_verifier_if.sv | 49 ++++
 rtl/pin_verifier.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pin_verifier_if.sv
// Bundles the swiper, keypad, PIN-table and session signals of pin_verifier.
//  slave  : the verifier's view (swiper/keypad/table data in, strobes and status out)
//  master : the environment's view (swiper, keypad, PIN table, transaction logic)
interface pin_verifier_if #(
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned ACC_W      = 16,
   parameter int unsigned PIN_DIGITS = 4
);
   // swiper
   logic                    card_scanned;
   logic [ADDR_W-1:0]       acc_addr;
   logic [ACC_W-1:0]        account_info;
   // keypad
   logic                    digit_valid;
   logic [3:0]              digit;
   logic                    digit_clear;
   // PIN table: read port returns {locked, pin}, write port sets the lock flag
   logic                    pin_rd_en;
   logic [ADDR_W-1:0]       pin_rd_addr;
   logic [4*PIN_DIGITS:0]   pin_rd_data;
   logic                    lock_wr_en;
   logic [ADDR_W-1:0]       lock_wr_addr;
   // session status
   logic                    session_valid;
   logic [ACC_W-1:0]        session_acc;
   logic                    auth_fail;
   logic                    card_locked;
   logic                    eject;
   logic [2:0]              tries_left;
   logic [2:0]              digits_in;

   modport slave (
      input  card_scanned, acc_addr, account_info,
      input  digit_valid, digit, digit_clear,
      input  pin_rd_data,
      output pin_rd_en, pin_rd_addr, lock_wr_en, lock_wr_addr,
      output session_valid, session_acc, auth_fail, card_locked, eject,
      output tries_left, digits_in
   );

   modport master (
      output card_scanned, acc_addr, account_info,
      output digit_valid, digit, digit_clear,
      output pin_rd_data,
      input  pin_rd_en, pin_rd_addr, lock_wr_en, lock_wr_addr,
      input  session_valid, session_acc, auth_fail, card_locked, eject,
      input  tries_left, digits_in
   );
endinterface

// File: rtl/pin_verifier.sv
// PIN verification stage behind the card swiper.
// On a new card it reads {locked, pin} for the account, collects keypad digits,
// compares them with the stored PIN, locks the account after MAX_TRIES misses
// and grants or denies the session.
// Ports:
//  clk  : clock
//  rst  : synchronous active-high reset
//  bus  : pin_verifier_if.slave (swiper, keypad, PIN table, session status)
// Every output is registered.
module pin_verifier #(
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned ACC_W      = 16,
   parameter int unsigned PIN_DIGITS = 4,
   parameter int unsigned MAX_TRIES  = 3,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic            clk,
   input  logic            rst,
   pin_verifier_if.slave   bus
);

   localparam int unsigned PIN_W = 4 * PIN_DIGITS;
   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_RDWAIT,
      S_ENTRY,
      S_CHECK,
      S_GRANTED,
      S_LOCKED,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic                 card_q;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [ACC_W-1:0]     acc_q, acc_d;
   logic [PIN_W-1:0]     pin_q, pin_d;
   logic [PIN_W-1:0]     entry_q, entry_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2:0]           digits_q, digits_d;
   logic [2:0]           tries_q, tries_d;
   logic                 pin_rd_en_q, pin_rd_en_d;
   logic                 lock_wr_en_q, lock_wr_en_d;
   logic                 session_valid_q, session_valid_d;
   logic [ACC_W-1:0]     session_acc_q, session_acc_d;
   logic                 auth_fail_q, auth_fail_d;
   logic                 card_locked_q, card_locked_d;
   logic                 eject_q, eject_d;

   logic                 digit_ok;

   assign digit_ok = bus.digit_valid && (bus.digit <= 4'd9);

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         // Treat the card as already present so a card held through reset must be re-inserted
         card_q          <= 1'b1;
         addr_q          <= '0;
         acc_q           <= '0;
         pin_q           <= '0;
         entry_q         <= '0;
         cnt_q           <= '0;
         digits_q        <= '0;
         tries_q         <= 3'(MAX_TRIES);
         pin_rd_en_q     <= 1'b0;
         lock_wr_en_q    <= 1'b0;
         session_valid_q <= 1'b0;
         session_acc_q   <= '0;
         auth_fail_q     <= 1'b0;
         card_locked_q   <= 1'b0;
         eject_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         card_q          <= bus.card_scanned;
         addr_q          <= addr_d;
         acc_q           <= acc_d;
         pin_q           <= pin_d;
         entry_q         <= entry_d;
         cnt_q           <= cnt_d;
         digits_q        <= digits_d;
         tries_q         <= tries_d;
         pin_rd_en_q     <= pin_rd_en_d;
         lock_wr_en_q    <= lock_wr_en_d;
         session_valid_q <= session_valid_d;
         session_acc_q   <= session_acc_d;
         auth_fail_q     <= auth_fail_d;
         card_locked_q   <= card_locked_d;
         eject_q         <= eject_d;
      end
   end

   // Next state and next output values
   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      acc_d           = acc_q;
      pin_d           = pin_q;
      entry_d         = entry_q;
      cnt_d           = cnt_q;
      digits_d        = digits_q;
      tries_d         = tries_q;
      pin_rd_en_d     = 1'b0;
      lock_wr_en_d    = 1'b0;
      session_valid_d = session_valid_q;
      session_acc_d   = session_acc_q;
      auth_fail_d     = 1'b0;
      card_locked_d   = card_locked_q;
      eject_d         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.card_scanned && !card_q) begin
               addr_d      = bus.acc_addr;
               acc_d       = bus.account_info;
               pin_rd_en_d = 1'b1;
               state_d     = S_FETCH;
            end
         end

         S_FETCH: begin
            state_d = S_RDWAIT;
         end

         S_RDWAIT: begin
            pin_d = bus.pin_rd_data[PIN_W-1:0];
            if (bus.pin_rd_data[PIN_W]) begin
               card_locked_d = 1'b1;
               eject_d       = 1'b1;
               state_d       = S_LOCKED;
            end else begin
               tries_d  = 3'(MAX_TRIES);
               digits_d = '0;
               entry_d  = '0;
               cnt_d    = '0;
               state_d  = S_ENTRY;
            end
         end

         S_ENTRY: begin
            if (bus.digit_clear) begin
               digits_d = '0;
               entry_d  = '0;
               cnt_d    = '0;
            end else if (digit_ok) begin
               // First digit ends up in the MSBs once all digits have been shifted in
               entry_d  = (entry_q << 4) | PIN_W'(bus.digit);
               digits_d = digits_q + 3'd1;
               cnt_d    = '0;
               if (digits_q == 3'(PIN_DIGITS - 1)) begin
                  state_d = S_CHECK;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               eject_d = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_CHECK: begin
            if (entry_q == pin_q) begin
               session_valid_d = 1'b1;
               session_acc_d   = acc_q;
               state_d         = S_GRANTED;
            end else if (tries_q == 3'd1) begin
               tries_d       = '0;
               lock_wr_en_d  = 1'b1;
               eject_d       = 1'b1;
               card_locked_d = 1'b1;
               state_d       = S_LOCKED;
            end else begin
               tries_d     = tries_q - 3'd1;
               auth_fail_d = 1'b1;
               digits_d    = '0;
               entry_d     = '0;
               cnt_d       = '0;
               state_d     = S_ENTRY;
            end
         end

         S_GRANTED, S_LOCKED, S_DONE: begin
            state_d = state_q;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Card removal wins over everything decided above, including a pending lock
      if ((state_q != S_IDLE) && !bus.card_scanned) begin
         state_d         = S_IDLE;
         pin_rd_en_d     = 1'b0;
         lock_wr_en_d    = 1'b0;
         auth_fail_d     = 1'b0;
         eject_d         = 1'b0;
         session_valid_d = 1'b0;
         session_acc_d   = '0;
         card_locked_d   = 1'b0;
         digits_d        = '0;
         tries_d         = 3'(MAX_TRIES);
         cnt_d           = '0;
      end
   end

   assign bus.pin_rd_en     = pin_rd_en_q;
   assign bus.pin_rd_addr   = addr_q;
   assign bus.lock_wr_en    = lock_wr_en_q;
   assign bus.lock_wr_addr  = addr_q;
   assign bus.session_valid = session_valid_q;
   assign bus.session_acc   = session_acc_q;
   assign bus.auth_fail     = auth_fail_q;
   assign bus.card_locked   = card_locked_q;
   assign bus.eject         = eject_q;
   assign bus.tries_left    = tries_q;
   assign bus.digits_in     = digits_q;

endmodule
